// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared mode encoding and channel-addressing helpers for the
// led_pwm_bank LED driver.
package led_pwm_pkg;

  // Width of the cfg_mode field.
  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  // Mode encoding. Codes 5..7 are reserved and drive the LED low.
  // MODE_BREATHE is only honoured when the breathe feature is compiled in.
  localparam mode_t MODE_OFF     = 3'd0;
  localparam mode_t MODE_ON      = 3'd1;
  localparam mode_t MODE_BLINK   = 3'd2;
  localparam mode_t MODE_PWM     = 3'd3;
  localparam mode_t MODE_BREATHE = 3'd4;

  // Width of an index able to address n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Out-of-range channel rule: a config whose channel number is not below
  // num_ch is always accepted (ready=1) and then silently dropped, so a
  // stray address can never stall the config port.
  function automatic logic ch_in_range(input int unsigned ch, input int unsigned num_ch);
    return ch < num_ch;
  endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// led_pwm_bank_if: valid/ready channel configuration port.
// The master raises cfg_valid with a target channel and settings; the
// transfer happens in any cycle where cfg_valid && cfg_ready.
interface led_pwm_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  import led_pwm_pkg::*;

  localparam int CH_W = idx_width(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  mode_t            cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    output cfg_ready
  );

endinterface

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one LED channel. Holds the period counter, active and
// shadow settings, the pending flag and the registered LED output.
// Optional feature macro: LED_BREATHE_EN adds the BREATHE mode
// (per-channel level ramp plus direction bit).
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 33_333_333
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_en,
  input  mode_t            wr_mode,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             pending,
  output logic             led
);

  localparam logic [CNT_W-1:0] DEF_PER  = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_DUTY = DEF_PER >> 1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  mode_t            act_mode_reg;
  logic [CNT_W-1:0] act_period_reg;
  logic [CNT_W-1:0] act_duty_reg;
  mode_t            shd_mode_reg;
  logic [CNT_W-1:0] shd_period_reg;
  logic [CNT_W-1:0] shd_duty_reg;
  logic             pending_reg;
  logic             led_reg;
  logic             led_next;

  logic boundary;
  logic commit;

  // Active period is never zero, so period-1 is always the last count.
  assign boundary = tick && (cnt_reg == (act_period_reg - ONE));
  // A commit needs a config that was already pending before this cycle;
  // one accepted in the boundary cycle itself waits for the next boundary.
  assign commit   = boundary && pending_reg;

  // Period counter: wraps to 0 at the boundary, which is also the restart
  // point for a freshly committed configuration.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      if (boundary) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + ONE;
      end
    end
  end

  // Shadow capture and pending flag. wr_en only arrives while not pending,
  // so it can never coincide with a commit.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      shd_mode_reg   <= MODE_BLINK;
      shd_period_reg <= DEF_PER;
      shd_duty_reg   <= DEF_DUTY;
      pending_reg    <= 1'b0;
    end else if (wr_en) begin
      shd_mode_reg   <= wr_mode;
      shd_period_reg <= (wr_period == '0) ? ONE : wr_period;
      shd_duty_reg   <= wr_duty;
      pending_reg    <= 1'b1;
    end else if (commit) begin
      pending_reg    <= 1'b0;
    end
  end

  // Active settings change only at a period boundary, so no short pulse.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      act_mode_reg   <= MODE_BLINK;
      act_period_reg <= DEF_PER;
      act_duty_reg   <= DEF_DUTY;
    end else if (commit) begin
      act_mode_reg   <= shd_mode_reg;
      act_period_reg <= shd_period_reg;
      act_duty_reg   <= shd_duty_reg;
    end
  end

`ifdef LED_BREATHE_EN
  logic [CNT_W-1:0] level_reg;
  logic             dir_fall_reg;
  logic [CNT_W:0]   level_sum;

  // One extra bit so level+step cannot wrap before the saturation test.
  assign level_sum = {1'b0, level_reg} + {1'b0, act_duty_reg};

  // Breathe ramp: step the level by duty at every boundary, saturating at
  // period (then falling) and at 0 (then rising).
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      level_reg    <= '0;
      dir_fall_reg <= 1'b0;
    end else if (commit) begin
      if (shd_mode_reg == MODE_BREATHE) begin
        level_reg    <= '0;
        dir_fall_reg <= 1'b0;
      end
    end else if (boundary && (act_mode_reg == MODE_BREATHE)) begin
      if (!dir_fall_reg) begin
        if (level_sum >= {1'b0, act_period_reg}) begin
          level_reg    <= act_period_reg;
          dir_fall_reg <= 1'b1;
        end else begin
          level_reg    <= level_sum[CNT_W-1:0];
        end
      end else begin
        if (level_reg <= act_duty_reg) begin
          level_reg    <= '0;
          dir_fall_reg <= 1'b0;
        end else begin
          level_reg    <= level_reg - act_duty_reg;
        end
      end
    end
  end
`endif

  // LED decode from the active settings and the current count.
  always_comb begin
    led_next = 1'b0;
    case (act_mode_reg)
      MODE_OFF:     led_next = 1'b0;
      MODE_ON:      led_next = 1'b1;
      MODE_BLINK:   led_next = (cnt_reg < (act_period_reg >> 1));
      MODE_PWM:     led_next = (cnt_reg < act_duty_reg);
`ifdef LED_BREATHE_EN
      MODE_BREATHE: led_next = (cnt_reg < level_reg);
`endif
      default:      led_next = 1'b0;
    endcase
  end

  // Registered LED drive, one cycle behind the counter.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      led_reg <= 1'b0;
    end else begin
      led_reg <= led_next;
    end
  end

  assign pending = pending_reg;
  assign led     = led_reg;

endmodule

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: NUM_CH-channel LED driver (OFF/ON/BLINK/PWM) with a shared
// prescaler and a valid/ready runtime configuration port. New settings are
// committed per channel at that channel's next period boundary.
// Optional feature macro: LED_BREATHE_EN enables mode 4 (BREATHE).
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRESCALE   = 1,
  parameter int DEF_PERIOD = 33_333_333
) (
  input  logic              sys_clk,
  input  logic              rst,
  led_pwm_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] led
);

  localparam int CH_W  = idx_width(NUM_CH);
  localparam int PAD_N = 2 ** CH_W;
  localparam int PC_W  = idx_width(PRESCALE);

  logic [PC_W-1:0]   pcnt_reg;
  logic              tick;
  logic [NUM_CH-1:0] pending;
  logic [PAD_N-1:0]  pending_pad;
  logic              ch_ok;
  logic              cfg_ready_w;
  logic              accept;

  assign tick = (pcnt_reg == PC_W'(PRESCALE - 1));

  // Prescaler: one tick every PRESCALE cycles (every cycle when PRESCALE=1).
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      pcnt_reg <= '0;
    end else if (tick) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_reg + PC_W'(1);
    end
  end

  // Pad the pending vector to the full cfg_ch range so the ready mux never
  // indexes past the end; out-of-range channels are forced ready anyway.
  assign pending_pad = PAD_N'(pending);
  assign ch_ok       = ch_in_range(32'(cfg.cfg_ch), NUM_CH);
  assign cfg_ready_w = ch_ok ? ~pending_pad[cfg.cfg_ch] : 1'b1;
  assign accept      = cfg.cfg_valid && cfg_ready_w;
  assign cfg.cfg_ready = cfg_ready_w;

  // One channel per LED; the write strobe is the decoded accepted address.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_en;
    assign wr_en = accept && (cfg.cfg_ch == CH_W'(gi));

    led_pwm_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_chan (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .tick      (tick),
      .wr_en     (wr_en),
      .wr_mode   (cfg.cfg_mode),
      .wr_period (cfg.cfg_period),
      .wr_duty   (cfg.cfg_duty),
      .pending   (pending[gi]),
      .led       (led[gi])
    );
  end

endmodule

// File: doc/led_pwm_bank.md
# led_pwm_bank

Parametrised multi-channel LED driver, the successor to the single fixed-rate blinker. Each of NUM_CH channels runs its own period counter from a shared prescaler tick and drives one LED in OFF, ON, BLINK or PWM mode. A valid/ready configuration port reprograms channels at runtime, with glitch-free commit at period boundaries. Sits at the board top level between the fabric clock and the LED pins.

## Interface
- NUM_CH, 4: number of LED channels, 1..16.
- CNT_W, 32: width of the period, duty and channel counters.
- PRESCALE, 1: sys_clk cycles per tick, ≥1 (1 means a tick every cycle).
- DEF_PERIOD, 33_333_333: reset period in ticks, 1..2^CNT_W-1.

- sys_clk  in  1  single clock, all logic posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; values ≥NUM_CH are accepted and dropped.
- cfg_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE (macro only), 5–7 reserved.
- cfg_period  in  CNT_W  period in ticks; 0 is treated as 1.
- cfg_duty  in  CNT_W  PWM high ticks; BREATHE step size.
- led  out  NUM_CH  registered LED drive, bit i = channel i.

## Operation
- Prescaler: pcnt counts 0..PRESCALE-1. tick=1 in the cycle pcnt==PRESCALE-1, then pcnt wraps to 0.
- Each channel on tick: cnt==period-1 → cnt=0 and boundary=1; otherwise cnt+1. cnt never exceeds period-1.
- Active registers per channel: mode, period, duty. Shadow registers plus a pending flag.
- Accepted config for channel c: writes shadow, sets pending[c]. At the next boundary of c, shadow is copied to active, pending clears, and cnt restarts at 0.
- cfg_ready = !pending[cfg_ch]. For an out-of-range cfg_ch, cfg_ready = 1 and the request is discarded.
- LED function of the active registers and cnt:
  - OFF → 0.
  - ON → 1.
  - BLINK → cnt < (period>>1); period 1 gives a constant 0.
  - PWM → cnt < duty; duty ≥ period gives a constant 1, duty 0 gives a constant 0.
  - Reserved modes → 0.
- Comparisons are unsigned, CNT_W wide. No overflow is possible because cnt < period ≤ 2^CNT_W-1.
- Reset: pcnt=0, every cnt=0, pending=0, active mode=BLINK, period=DEF_PERIOD, duty=DEF_PERIOD>>1, led=0.

## Timing
- led is registered: it reflects the cnt and active registers of the previous cycle, one cycle of latency.
- First cycle after rst deasserts: led=0. Second cycle: led=1 (BLINK, cnt 0 < DEF_PERIOD>>1).
- Handshake: cfg_ready drops in the cycle after acceptance for that channel. It rises in the cycle after the commit boundary.
- Accept and boundary of the same channel in the same cycle: the new config goes to shadow and commits at the following boundary, not the current one.
- Configs to different channels are independent and may be accepted back-to-back, one per cycle.
- rst mid-period or with a pending config: pending is discarded and all state returns to reset values on the next edge.
- Period change takes effect only at a boundary. No partial or short pulse is emitted.

## Configuration
- LED_BREATHE_EN defined: mode 4 BREATHE is available.
  - Per-channel level register starts at 0 and a direction bit starts rising.
  - At each boundary, level moves ±duty and saturates at period or 0. The direction reverses on saturation.
  - led = cnt < level.
  - A commit into BREATHE resets level to 0 and direction to rising.
- LED_BREATHE_EN undefined: mode 4 is reserved (led=0) and no level/direction logic is built.

## Structure
- Package led_pwm_pkg holds:
  - the mode encoding localparams or enum (MODE_OFF, MODE_ON, MODE_BLINK, MODE_PWM, MODE_BREATHE);
  - the mode width constant (3);
  - the out-of-range channel rule as a documented constant function.
- Sub-module led_pwm_chan, instantiated NUM_CH times, holds one channel's cnt, active/shadow/pending registers, breathe state and led flop.
- The top level holds the prescaler, cfg_ch decode and cfg_ready mux.

## Test plan
- Reset, NUM_CH=2, PRESCALE=1, DEF_PERIOD=10 → both leds high 5 cycles, low 5 cycles, starting 2 cycles after rst deasserts.
- Config ch1 PWM period 8, duty 3 mid-period → cfg_ready low until ch1's boundary. Then 3 high, 5 low repeating; ch0 undisturbed.
- PWM duty 0, then duty 20 with period 8 → constant 0, then constant 1. Period 0 behaves as period 1.
- Accept for ch0 in the exact cycle of its boundary → commit occurs one full period later. A second request while pending is held off by cfg_ready=0.
- PRESCALE=4, BLINK period 4 → led high 8 cycles, low 8 cycles. cfg_ch=3 with NUM_CH=2 → accepted, no channel changes.
- With LED_BREATHE_EN, period 4, step 1 → per-period high counts 1,2,3,4,3,2,1,0,1… Without the macro, mode 4 → led=0.
